el2_lsu_bus_clken_gen: RTL and testbench



---
 rtl/el2_pkg.sv | 13 +
 rtl/el2_lsu_bus_ratio_cnt.sv | 43 ++++
 rtl/el2_lsu_bus_clken_gen.sv | 100 ++++++++++
 tb/tb_el2_lsu_bus_clken_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared types for the LSU bus clock-ratio logic.
// Holds the ratio-change FSM encoding and the default ratio width.
package el2_pkg;

    localparam int EL2_BUS_RATIO_W = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ALIGN = 2'd2
    } el2_bus_ratio_fsm_t;

endpackage

// File: rtl/el2_lsu_bus_ratio_cnt.sv
// Bus-edge down-counter for the LSU core/bus clock ratio.
// Ports: clk, rst, ratio_cur, load/load_val (next reload override),
//        scan_mode, cnt_zero, en, en_nxt.
module el2_lsu_bus_ratio_cnt
    import el2_pkg::*;
#(
    parameter int RATIO_W = EL2_BUS_RATIO_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATIO_W-1:0] ratio_cur,
    input  logic               load,
    input  logic [RATIO_W-1:0] load_val,
    input  logic               scan_mode,
    output logic               cnt_zero,
    output logic               en,
    output logic               en_nxt
);

    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] reload;

    // While a switch is armed, the next bus edge reloads with the
    // new ratio, so en_nxt stays exact across the switch cycle.
    assign reload   = load ? load_val : ratio_cur;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_zero) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - RATIO_W'(1);
        end
    end

    assign en     = cnt_zero | scan_mode;
    assign en_nxt = (cnt == RATIO_W'(1))
                  | (cnt_zero & (reload == '0))
                  | scan_mode;

endmodule

// File: rtl/el2_lsu_bus_clken_gen.sv
// LSU bus clock-enable generator with safe run-time ratio change.
// Ports: clk, rst, ratio_req_vld/ratio_req/ratio_req_rdy,
//        lsu_bus_buffer_empty_any, lsu_busreq_r, scan_mode,
//        lsu_bus_clk_en, lsu_bus_clk_en_nxt, bus_ratio_cur,
//        bus_block_req.
module el2_lsu_bus_clken_gen
    import el2_pkg::*;
#(
    parameter int RATIO_W     = EL2_BUS_RATIO_W,
    parameter int RESET_RATIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ratio_req_vld,
    input  logic [RATIO_W-1:0] ratio_req,
    output logic               ratio_req_rdy,
    input  logic               lsu_bus_buffer_empty_any,
    input  logic               lsu_busreq_r,
    input  logic               scan_mode,
    output logic               lsu_bus_clk_en,
    output logic               lsu_bus_clk_en_nxt,
    output logic [RATIO_W-1:0] bus_ratio_cur,
    output logic               bus_block_req
);

    localparam logic [RATIO_W-1:0] RST_RATIO = RATIO_W'(RESET_RATIO);

    el2_bus_ratio_fsm_t fsm;
    el2_bus_ratio_fsm_t fsm_nxt;

    logic [RATIO_W-1:0] ratio_cur;
    logic [RATIO_W-1:0] ratio_cur_nxt;
    logic [RATIO_W-1:0] ratio_pend;
    logic [RATIO_W-1:0] ratio_pend_nxt;
    logic               cnt_zero;
    logic               align;

    assign align = (fsm == ALIGN);

    el2_lsu_bus_ratio_cnt #(
        .RATIO_W (RATIO_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .ratio_cur (ratio_cur),
        .load      (align),
        .load_val  (ratio_pend),
        .scan_mode (scan_mode),
        .cnt_zero  (cnt_zero),
        .en        (lsu_bus_clk_en),
        .en_nxt    (lsu_bus_clk_en_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= RUN;
            ratio_cur  <= RST_RATIO;
            ratio_pend <= RST_RATIO;
        end else begin
            fsm        <= fsm_nxt;
            ratio_cur  <= ratio_cur_nxt;
            ratio_pend <= ratio_pend_nxt;
        end
    end

    always_comb begin
        fsm_nxt        = fsm;
        ratio_cur_nxt  = ratio_cur;
        ratio_pend_nxt = ratio_pend;
        unique case (fsm)
            RUN: begin
                // Equal-ratio request is accepted as a no-op.
                if (ratio_req_vld && (ratio_req != ratio_cur)) begin
                    ratio_pend_nxt = ratio_req;
                    fsm_nxt        = DRAIN;
                end
            end
            DRAIN: begin
                if (lsu_bus_buffer_empty_any && !lsu_busreq_r) begin
                    fsm_nxt = ALIGN;
                end
            end
            ALIGN: begin
                // Switch only on an old-ratio bus edge.
                if (cnt_zero) begin
                    ratio_cur_nxt = ratio_pend;
                    fsm_nxt       = RUN;
                end
            end
            default: begin
                fsm_nxt = RUN;
            end
        endcase
    end

    assign ratio_req_rdy = (fsm == RUN);
    assign bus_block_req = (fsm != RUN);
    assign bus_ratio_cur = ratio_cur;

endmodule

// File: tb/tb_el2_lsu_bus_clken_gen.sv
// Testbench for el2_lsu_bus_clken_gen: directed vector table,
// hand-written drain sequence and random run against a model.
module tb_el2_lsu_bus_clken_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic [2:0] req = 3'd0;
    logic       rdy;
    logic       empty = 1'b1;
    logic       busreq = 1'b0;
    logic       scan = 1'b0;
    logic       en;
    logic       en_nxt;
    logic [2:0] cur;
    logic       blk;

    always #5 clk = ~clk;

    el2_lsu_bus_clken_gen #(
        .RATIO_W     (3),
        .RESET_RATIO (0)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .ratio_req_vld            (vld),
        .ratio_req                (req),
        .ratio_req_rdy            (rdy),
        .lsu_bus_buffer_empty_any (empty),
        .lsu_busreq_r             (busreq),
        .scan_mode                (scan),
        .lsu_bus_clk_en           (en),
        .lsu_bus_clk_en_nxt       (en_nxt),
        .bus_ratio_cur            (cur),
        .bus_block_req            (blk)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: bus edges fall at base + k*(m_cur+1).
    int m_cyc = 0;
    int m_base = 0;
    int m_cur = 0;
    int m_pend = 0;
    bit m_valid = 1'b0;
    bit m_wait_empty = 1'b0;
    bit m_wait_edge = 1'b0;
    bit m_step_rst = 1'b0;
    bit p_ok = 1'b0;
    bit p_nxt = 1'b0;
    bit p_scan = 1'b0;

    function automatic bit edge_at(input int c);
        return ((c - m_base) % (m_cur + 1)) == 0;
    endfunction

    task automatic model_update();
        bit e;
        e = edge_at(m_cyc);
        m_step_rst = rst;
        if (rst) begin
            m_valid      = 1'b1;
            m_cur        = 0;
            m_pend       = 0;
            m_wait_empty = 1'b0;
            m_wait_edge  = 1'b0;
            m_base       = m_cyc + 1;
        end else if (m_wait_edge) begin
            if (e) begin
                m_cur       = m_pend;
                m_base      = m_cyc;
                m_wait_edge = 1'b0;
            end
        end else if (m_wait_empty) begin
            if (empty && !busreq) begin
                m_wait_empty = 1'b0;
                m_wait_edge  = 1'b1;
            end
        end else if (vld && (int'(req) != m_cur)) begin
            m_pend       = int'(req);
            m_wait_empty = 1'b1;
        end
        m_cyc++;
    endtask

    task automatic model_check();
        bit busy;
        if (!m_valid) return;
        busy = m_wait_empty | m_wait_edge;
        chk("m_en", int'(en), int'(edge_at(m_cyc) | scan));
        chk("m_rdy", int'(rdy), int'(!busy));
        chk("m_blk", int'(blk), int'(busy));
        chk("m_cur", int'(cur), m_cur);
        if (scan) chk("m_nxt_scan", int'(en_nxt), 1);
        if (p_ok && !p_scan && !scan && !m_step_rst)
            chk("m_nxt_pred", int'(en), int'(p_nxt));
        p_ok   = 1'b1;
        p_nxt  = en_nxt;
        p_scan = scan;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        bit       rst;
        bit       vld;
        bit [2:0] req;
        bit       empty;
        bit       scan;
        bit       en;
        bit       nxt;
        bit       rdy;
        bit       blk;
        bit [2:0] cur;
    } vec_t;

    function automatic vec_t mk(
        input bit r, input bit v, input int q, input bit e,
        input bit s, input bit xen, input bit xnx,
        input bit xrd, input bit xbl, input int xcu);
        vec_t t;
        t.rst = r; t.vld = v; t.req = 3'(q);
        t.empty = e; t.scan = s;
        t.en = xen; t.nxt = xnx; t.rdy = xrd;
        t.blk = xbl; t.cur = 3'(xcu);
        return t;
    endfunction

    vec_t tbl[28];

    initial begin
        bit prev_en;
        bit seen;
        //            rst v  q  emp sc  en nx rd bl cur
        tbl[0]  = mk(1, 0, 0, 1, 0,  1, 1, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0,  1, 1, 1, 0, 0);
        tbl[2]  = mk(0, 1, 3, 1, 0,  1, 1, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
        tbl[5]  = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
        tbl[6]  = mk(0, 0, 0, 1, 0,  0, 1, 1, 0, 3);
        tbl[7]  = mk(0, 0, 0, 1, 0,  1, 0, 1, 0, 3);
        tbl[8]  = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
        tbl[9]  = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
        tbl[10] = mk(0, 0, 0, 1, 0,  0, 1, 1, 0, 3);
        tbl[11] = mk(0, 0, 0, 1, 0,  1, 0, 1, 0, 3);
        tbl[12] = mk(0, 1, 3, 1, 0,  0, 0, 1, 0, 3);
        tbl[13] = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
        tbl[14] = mk(0, 0, 0, 1, 0,  0, 1, 1, 0, 3);
        tbl[15] = mk(0, 0, 0, 1, 0,  1, 0, 1, 0, 3);
        tbl[16] = mk(0, 1, 5, 0, 0,  0, 0, 0, 1, 3);
        tbl[17] = mk(1, 0, 0, 0, 0,  1, 1, 1, 0, 0);
        tbl[18] = mk(0, 1, 3, 1, 0,  1, 1, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
        tbl[21] = mk(0, 0, 0, 1, 1,  1, 1, 1, 0, 3);
        tbl[22] = mk(0, 0, 0, 1, 1,  1, 1, 1, 0, 3);
        tbl[23] = mk(0, 0, 0, 1, 0,  1, 0, 1, 0, 3);
        tbl[24] = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
        tbl[25] = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
        tbl[26] = mk(0, 0, 0, 1, 0,  0, 1, 1, 0, 3);
        tbl[27] = mk(0, 0, 0, 1, 0,  1, 0, 1, 0, 3);

        for (int i = 0; i < 28; i++) begin
            rst    = tbl[i].rst;
            vld    = tbl[i].vld;
            req    = tbl[i].req;
            empty  = tbl[i].empty;
            busreq = 1'b0;
            scan   = tbl[i].scan;
            step();
            chk($sformatf("v%0d_en", i), int'(en), int'(tbl[i].en));
            chk($sformatf("v%0d_nxt", i), int'(en_nxt), int'(tbl[i].nxt));
            chk($sformatf("v%0d_rdy", i), int'(rdy), int'(tbl[i].rdy));
            chk($sformatf("v%0d_blk", i), int'(blk), int'(tbl[i].blk));
            chk($sformatf("v%0d_cur", i), int'(cur), int'(tbl[i].cur));
        end

        // Buffer busy for 10 cycles after accepting ratio 1.
        rst = 1'b0; scan = 1'b0;
        vld = 1'b1; req = 3'd1; empty = 1'b0;
        step();
        vld = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("drain_blk", int'(blk), 1);
            chk("drain_rdy", int'(rdy), 0);
            chk("drain_cur", int'(cur), 3);
        end
        empty = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            prev_en = en;
            step();
            if (cur == 3'd1) begin
                seen = 1'b1;
                chk("switch_on_edge", int'(prev_en), 1);
                chk("switch_en_after", int'(en), 0);
                chk("switch_blk", int'(blk), 0);
            end
        end
        if (!seen) chk("switch_timeout", 0, 1);

        // Random run against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            vld    = ($urandom_range(0, 7) == 0);
            req    = 3'($urandom_range(0, 7));
            empty  = ($urandom_range(0, 9) < 7);
            busreq = ($urandom_range(0, 4) == 0);
            scan   = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
